// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch unit: datapath widths, next-PC select
// encodings, fetch FSM state type and the default reset PC.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_CTRL_W = 3;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Next-PC select from the control unit; codes 3'b100..3'b111 are illegal
  typedef enum logic [PC_CTRL_W-1:0] {
    PC_INC    = 3'b000,
    PC_JUMP   = 3'b001,
    PC_JR     = 3'b010,
    PC_BRANCH = 3'b011
  } pc_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : fetch address (fetch unit -> memory)
//   imem_ack   : request accepted, imem_rdata valid this cycle (memory -> fetch unit)
//   imem_rdata : fetched instruction word (memory -> fetch unit)
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection.
//   pc, instruction, rs_value, pc_control : inputs
//   next_pc : selected next PC
//   err     : illegal pc_control code or misaligned jr target
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      instruction,
  input  logic [XLEN-1:0]      rs_value,
  input  logic [PC_CTRL_W-1:0] pc_control,
  output logic [XLEN-1:0]      next_pc,
  output logic                 err
);

  logic [XLEN-1:0] p4;
  logic [XLEN-1:0] br_off;
  logic            unused_opcode;

  assign p4     = pc + XLEN'(4);
  // Sign-extended 16-bit immediate scaled to a word offset
  assign br_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  // Opcode bits are decoded by the control unit, not here
  assign unused_opcode = ^instruction[31:26];

  always_comb begin
    next_pc = p4;
    err     = 1'b0;
    case (pc_control)
      PC_INC:    next_pc = p4;
      PC_JUMP:   next_pc = {p4[31:28], instruction[25:0], 2'b00};
      PC_JR: begin
        next_pc = {rs_value[31:2], 2'b00};
        err     = |rs_value[1:0];
      end
      PC_BRANCH: next_pc = p4 + br_off;
      default: begin
        next_pc = p4;
        err     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch and program counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory request/ack bus (master side)
//   instruction  : instruction register feeding the control unit
//   instr_valid  : instruction valid, awaiting pc_update
//   pc_update    : execute has resolved the current instruction
//   pc_control   : next-PC select
//   rs_value     : jr target
//   pc           : address of the current instruction
//   link_addr    : pc + 4 (combinational), jal return address
//   pc_err       : one-cycle pulse on illegal select or misaligned jr target
//   instr_count  : number of retired instructions
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_fetch_unit_if.master      imem,
  output logic [XLEN-1:0]      instruction,
  output logic                 instr_valid,
  input  logic                 pc_update,
  input  logic [PC_CTRL_W-1:0] pc_control,
  input  logic [XLEN-1:0]      rs_value,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      link_addr,
  output logic                 pc_err,
  output logic [XLEN-1:0]      instr_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] calc_next_pc;
  logic            calc_err;

  next_pc_calc u_next_pc_calc (
    .pc          (pc_q),
    .instruction (instr_q),
    .rs_value    (rs_value),
    .pc_control  (pc_control),
    .next_pc     (calc_next_pc),
    .err         (calc_err)
  );

  // Next-state and next-output logic; outputs are registered below
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = 1'b0;
    req_d   = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        req_d = 1'b1;
        if (imem.imem_ack) begin
          state_d = S_ISSUE;
          instr_d = imem.imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        valid_d = 1'b1;
        if (pc_update) begin
          state_d = S_REQ;
          pc_d    = calc_next_pc;
          count_d = count_q + XLEN'(1);
          err_d   = calc_err;
          valid_d = 1'b0;
          req_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign link_addr      = pc_q + XLEN'(4);
  assign pc_err         = err_q;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        pc_update;
  logic [2:0]  pc_control;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        pc_err;
  logic [31:0] instr_count;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc_update   (pc_update),
    .pc_control  (pc_control),
    .rs_value    (rs_value),
    .pc          (pc),
    .link_addr   (link_addr),
    .pc_err      (pc_err),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        err;
  } fexp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  ctrl;
    logic [31:0] rs;
    int          dly;
    bit          inj;
    logic [31:0] nxt;
    bit          err;
  } vec_t;

  fexp_t       fq[$];
  logic [31:0] iq[$];
  vec_t        vt[13];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [31:0] instr, logic [2:0] ctrl, logic [31:0] rs,
                              int dly, bit inj, logic [31:0] nxt, bit err);
    vec_t v;
    v.instr = instr; v.ctrl = ctrl; v.rs = rs; v.dly = dly;
    v.inj = inj; v.nxt = nxt; v.err = err;
    return v;
  endfunction

  task automatic wait_req();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.imem_req) break;
    end
    if (i == 50) chk("req_timeout", 32'(bus.imem_req), 32'd1);
  endtask

  // Memory responder + control-unit stimulus for one instruction
  task automatic run_vec(input int k, input vec_t v);
    wait_req();
    for (int d = 0; d < v.dly; d++) begin
      if (v.inj && d == 0) begin
        pc_update  = 1'b1;
        pc_control = 3'b001;
      end
      @(negedge clk);
      pc_update = 1'b0;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.instr;
    iq.push_back(v.instr);
    @(posedge clk);
    #1 chk("valid_after_ack", 32'(instr_valid), 32'd1);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    pc_update    = 1'b1;
    pc_control   = v.ctrl;
    rs_value     = v.rs;
    fq.push_back('{addr: v.nxt, cnt: 32'(k + 1), err: v.err});
    @(negedge clk);
    pc_update = 1'b0;
  endtask

  // Monitor: checks fetch requests and issued instructions against the scoreboard
  logic        pr, pv;
  logic [31:0] held;
  fexp_t       e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pr   = 1'b0;
      pv   = 1'b0;
      held = 32'h0;
    end else begin
      if (bus.imem_req && instr_valid) chk("req_and_valid", 32'd1, 32'd0);
      if (bus.imem_req && !pr) begin
        if (fq.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
        else begin
          e = fq.pop_front();
          held = e.addr;
          chk("fetch_addr", bus.imem_addr, e.addr);
          chk("pc", pc, e.addr);
          chk("instr_count", instr_count, e.cnt);
          chk("pc_err", 32'(pc_err), 32'(e.err));
        end
      end else begin
        chk("pc_err_quiet", 32'(pc_err), 32'd0);
        if (bus.imem_req) chk("addr_stable", bus.imem_addr, held);
      end
      if (instr_valid && !pv) begin
        if (iq.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
        else chk("instruction", instruction, iq.pop_front());
        chk("link_addr", link_addr, held + 32'd4);
      end
      pr = bus.imem_req;
      pv = instr_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_update = 1'b0; pc_control = 3'b000; rs_value = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;

    vt[0]  = mk(32'h0000_0000, 3'b010, 32'h0000_0100, 0, 0, 32'h0000_0100, 0);
    vt[1]  = mk(32'h0000_0000, 3'b000, 32'h0,         0, 0, 32'h0000_0104, 0);
    vt[2]  = mk(32'h0000_0000, 3'b010, 32'h4000_0010, 1, 0, 32'h4000_0010, 0);
    vt[3]  = mk(32'h0800_0040, 3'b001, 32'h0,         0, 0, 32'h4000_0100, 0);
    vt[4]  = mk(32'h0000_0000, 3'b010, 32'h0000_0200, 0, 0, 32'h0000_0200, 0);
    vt[5]  = mk(32'h1000_FFFE, 3'b011, 32'h0,         0, 0, 32'h0000_01FC, 0);
    vt[6]  = mk(32'h0000_0000, 3'b010, 32'h0000_0200, 0, 0, 32'h0000_0200, 0);
    vt[7]  = mk(32'h1000_FFFE, 3'b000, 32'h0,         0, 0, 32'h0000_0204, 0);
    vt[8]  = mk(32'h0000_0000, 3'b010, 32'h0000_1003, 0, 0, 32'h0000_1000, 1);
    vt[9]  = mk(32'h0000_0000, 3'b101, 32'h0,         5, 1, 32'h0000_1004, 1);
    vt[10] = mk(32'h0000_0000, 3'b010, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0);
    vt[11] = mk(32'h0000_0000, 3'b000, 32'h0,         0, 0, 32'h0000_0000, 0);
    vt[12] = mk(32'h0000_7FFF, 3'b011, 32'h0,         2, 0, 32'h0002_0000, 0);

    fq.push_back('{addr: 32'h0, cnt: 32'h0, err: 1'b0});
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("req_after_release", 32'(bus.imem_req), 32'd1);

    for (int k = 0; k < 13; k++) run_vec(k, vt[k]);

    // Reset while an instruction is being issued
    wait_req();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    iq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("issue_before_rst", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    pc_update = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instr", instruction, 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_err", 32'(pc_err), 32'd0);
    chk("mid_rst_count", instr_count, 32'h0);
    @(negedge clk);
    pc_update = 1'b0;
    fq.push_back('{addr: 32'h0, cnt: 32'h0, err: 1'b0});
    #3 rst_n = 1'b1;

    run_vec(0, mk(32'h0000_0000, 3'b000, 32'h0, 0, 0, 32'h0000_0004, 0));
    repeat (3) @(negedge clk);
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("instr_queue_drained", 32'(iq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
